// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive buffer: byte width, FIFO geometry and error counter width.
package uart_rx_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_FIFO_DEPTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 3;
  localparam int DEF_ERR_CNT_WIDTH = 8;

endpackage : uart_rx_fifo_pkg

// File: rtl/uart_rx_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read for first-word-fall-through.
module uart_rx_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH,
  parameter int AW         = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; occupancy comes from the pointers, so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : uart_rx_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART RX FSM, with sticky error flags and saturating error counters.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int Out_Data_width = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int ERR_CNT_WIDTH  = DEF_ERR_CNT_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [Out_Data_width-1:0] P_DATA,
  input  logic                      Data_Valid,
  input  logic                      par_err,
  input  logic                      stp_err,
  input  logic                      FLUSH,
  input  logic                      CLR_ERR,
  output logic [Out_Data_width-1:0] RD_DATA,
  output logic                      RD_VALID,
  input  logic                      RD_READY,
  output logic                      FULL,
  output logic [ADDR_WIDTH:0]       LEVEL,
  output logic                      OVF_FLAG,
  output logic                      PAR_FLAG,
  output logic                      STP_FLAG,
  output logic [ERR_CNT_WIDTH-1:0]  PAR_CNT,
  output logic [ERR_CNT_WIDTH-1:0]  STP_CNT,
  output logic [ERR_CNT_WIDTH-1:0]  OVF_CNT
);

  logic [ADDR_WIDTH:0]      wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic                     ovf_flag_q, ovf_flag_d, par_flag_q, par_flag_d, stp_flag_q, stp_flag_d;
  logic [ERR_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d, par_cnt_q, par_cnt_d, stp_cnt_q, stp_cnt_d;
  logic                     empty, full, pop, push, ovf;

  // A new event in the clearing cycle restarts its counter at 1 rather than 0.
  function automatic logic [ERR_CNT_WIDTH-1:0] cnt_next(input logic                     ev,
                                                        input logic                     clr,
                                                        input logic [ERR_CNT_WIDTH-1:0] cnt);
    if (ev && clr)   return ERR_CNT_WIDTH'(1);
    else if (ev)     return (&cnt) ? cnt : cnt + ERR_CNT_WIDTH'(1);
    else if (clr)    return '0;
    else             return cnt;
  endfunction

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                 (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

  // A flush discards both the incoming byte and any pop requested in the same cycle.
  assign pop  = !empty && RD_READY && !FLUSH;
  assign push = Data_Valid && !FLUSH && (!full || pop);
  assign ovf  = Data_Valid && !FLUSH && full && !pop;

  // NOTE: every variable driven here gets a default at the top, so no path can infer a latch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + (ADDR_WIDTH+1)'(1);
    if (FLUSH)    rptr_d = wptr_q;
    else if (pop) rptr_d = rptr_q + (ADDR_WIDTH+1)'(1);
    level_d = wptr_d - rptr_d;

    par_flag_d = par_err | (par_flag_q & ~CLR_ERR);
    stp_flag_d = stp_err | (stp_flag_q & ~CLR_ERR);
    ovf_flag_d = ovf     | (ovf_flag_q & ~CLR_ERR);
    par_cnt_d  = cnt_next(par_err, CLR_ERR, par_cnt_q);
    stp_cnt_d  = cnt_next(stp_err, CLR_ERR, stp_cnt_q);
    ovf_cnt_d  = cnt_next(ovf,     CLR_ERR, ovf_cnt_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
      par_cnt_q  <= '0;
      stp_cnt_q  <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      ovf_flag_q <= ovf_flag_d;
      par_cnt_q  <= par_cnt_d;
      stp_cnt_q  <= stp_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  uart_rx_fifo_mem #(
    .DATA_WIDTH (Out_Data_width),
    .DEPTH      (FIFO_DEPTH),
    .AW         (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (push),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (P_DATA),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (RD_DATA)
  );

  assign RD_VALID = !empty;
  assign FULL     = full;
  assign LEVEL    = level_q;
  assign OVF_FLAG = ovf_flag_q;
  assign PAR_FLAG = par_flag_q;
  assign STP_FLAG = stp_flag_q;
  assign PAR_CNT  = par_cnt_q;
  assign STP_CNT  = stp_cnt_q;
  assign OVF_CNT  = ovf_cnt_q;

endmodule : uart_rx_fifo
